// File: rtl/hdmi_pattern_ctrl.sv
// Test-pattern controller for the hdmi pixel path: debounced board keys select
// one of four patterns, with a frame-aligned black-out on every mode change.
module hdmi_pattern_ctrl #(
    parameter logic [19:0]  DEBOUNCE_CYCLES = 20'd500000,
    parameter int unsigned  MUTE_FRAMES     = 2,
    parameter logic [1:0]   DEFAULT_MODE    = 2'd2
) (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic [3:0]  key,
    input  logic [9:0]  cx,
    input  logic [9:0]  cy,
    input  logic [9:0]  screen_width,
    input  logic [9:0]  screen_height,
    input  logic [2:0]  game_rgb,
    output logic [23:0] rgb,
    output logic [1:0]  mode,
    output logic        muted
);

    localparam int unsigned NKEY = 4;
    localparam int unsigned CW   = 20;
    localparam int unsigned MCW  = (MUTE_FRAMES > 1) ? $clog2(MUTE_FRAMES) : 1;

    localparam logic [CW-1:0]  DEBOUNCE_LAST = DEBOUNCE_CYCLES - CW'(1);
    localparam logic [MCW-1:0] MUTE_LAST     = MCW'(MUTE_FRAMES - 1);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_PEND = 2'd1,
        S_MUTE = 2'd2
    } state_t;

    logic [NKEY-1:0] sync1;
    logic [NKEY-1:0] sync2;
    logic [NKEY-1:0] db;
    logic [NKEY-1:0] press;
    logic [CW-1:0]   db_cnt [NKEY];

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      mode_nxt;
    logic [1:0]      target;
    logic [1:0]      target_nxt;
    logic [MCW-1:0]  mute_cnt;
    logic [MCW-1:0]  mute_cnt_nxt;
    logic [7:0]      frame_cnt;
    logic [7:0]      frame_cnt_nxt;
    logic            paused;
    logic            paused_nxt;
    logic            frame_start;
    logic            mode_evt;
    logic [9:0]      third;
    logic [9:0]      two_third;
    logic [23:0]     pix_c;

    // Synchronize, debounce and edge-detect the active-low keys; press fires on accepted 1->0.
    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
            db    <= '1;
            press <= '0;
            for (int i = 0; i < NKEY; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            for (int i = 0; i < NKEY; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DEBOUNCE_LAST) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                    press[i]  <= db[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    function automatic logic [1:0] step_mode(input logic [1:0] base, input logic [3:0] ev);
        if (ev[3]) begin
            return DEFAULT_MODE;
        end else if (ev[0]) begin
            return base + 2'd1;
        end else begin
            return base - 2'd1;
        end
    endfunction

    assign frame_start = (cx == '0) && (cy == '0);
    assign mode_evt    = press[3] | press[0] | press[1];

    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            state     <= S_RUN;
            mode      <= DEFAULT_MODE;
            target    <= DEFAULT_MODE;
            mute_cnt  <= '0;
            frame_cnt <= '0;
            paused    <= 1'b0;
            rgb       <= '0;
            muted     <= 1'b0;
        end else begin
            state     <= state_nxt;
            mode      <= mode_nxt;
            target    <= target_nxt;
            mute_cnt  <= mute_cnt_nxt;
            frame_cnt <= frame_cnt_nxt;
            paused    <= paused_nxt;
            rgb       <= pix_c;
            muted     <= (state_nxt == S_MUTE);
        end
    end

    // Mode sequencing: changes are queued in PEND and committed only on a frame boundary.
    always_comb begin
        state_nxt     = state;
        mode_nxt      = mode;
        target_nxt    = target;
        mute_cnt_nxt  = mute_cnt;
        frame_cnt_nxt = frame_cnt;
        paused_nxt    = paused ^ press[2];

        if (frame_start && !paused) begin
            frame_cnt_nxt = frame_cnt + 8'd1;
        end

        case (state)
            S_RUN: begin
                if (mode_evt) begin
                    target_nxt = step_mode(mode, press);
                    if (target_nxt != mode) begin
                        state_nxt = S_PEND;
                    end
                end
            end
            S_PEND: begin
                if (mode_evt) begin
                    target_nxt = step_mode(target, press);
                end
                if (frame_start) begin
                    if (target_nxt == mode) begin
                        state_nxt = S_RUN;
                    end else begin
                        mode_nxt     = target_nxt;
                        mute_cnt_nxt = '0;
                        state_nxt    = S_MUTE;
                    end
                end
            end
            S_MUTE: begin
                if (frame_start) begin
                    if (mute_cnt == MUTE_LAST) begin
                        state_nxt = S_RUN;
                    end else begin
                        mute_cnt_nxt = mute_cnt + MCW'(1);
                    end
                end
            end
            default: begin
                state_nxt = S_RUN;
            end
        endcase
    end

    assign third     = screen_height / 10'd3;
    assign two_third = third << 1;

    // Pixel generator uses next-cycle mode/state so blanking and mode switch land on pixel (0,0).
    always_comb begin
        pix_c = '0;
        case (mode_nxt)
            2'd0: begin
                if (cy < third) begin
                    pix_c = 24'hff0000;
                end else if (cy < two_third) begin
                    pix_c = 24'h00ff00;
                end else begin
                    pix_c = 24'h0000ff;
                end
            end
            2'd1: begin
                if ((cx == '0) || (cy == '0) ||
                    (cx == screen_width - 10'd1) || (cy == screen_height - 10'd1)) begin
                    pix_c = 24'hffffff;
                end
            end
            2'd2: begin
                pix_c = {{8{game_rgb[2]}}, {8{game_rgb[1]}}, {8{game_rgb[0]}}};
            end
            default: begin
                pix_c = {cx[7:0] + frame_cnt_nxt, cy[7:0], frame_cnt_nxt};
            end
        endcase
        if ((cx >= screen_width) || (cy >= screen_height) || (state_nxt == S_MUTE)) begin
            pix_c = '0;
        end
    end

endmodule

// File: tb/tb_hdmi_pattern_ctrl.sv
// Randomized bench for hdmi_pattern_ctrl: raster and random-coordinate stimulus
// with random key activity, checked every cycle against a behavioural model.
module tb_hdmi_pattern_ctrl;

    localparam int         DEB = 4;
    localparam int         MF  = 2;
    localparam logic [1:0] DEF = 2'd2;

    logic        clk_pixel = 1'b0;
    logic        rst_n;
    logic [3:0]  key;
    logic [9:0]  cx;
    logic [9:0]  cy;
    logic [9:0]  sw;
    logic [9:0]  sh;
    logic [2:0]  game_rgb;
    logic [23:0] rgb;
    logic [1:0]  mode;
    logic        muted;

    hdmi_pattern_ctrl #(
        .DEBOUNCE_CYCLES (20'(DEB)),
        .MUTE_FRAMES     (MF),
        .DEFAULT_MODE    (DEF)
    ) dut (
        .clk_pixel     (clk_pixel),
        .rst_n         (rst_n),
        .key           (key),
        .cx            (cx),
        .cy            (cy),
        .screen_width  (sw),
        .screen_height (sh),
        .game_rgb      (game_rgb),
        .rgb           (rgb),
        .mode          (mode),
        .muted         (muted)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Behavioural model state
    logic [3:0]  m_s1, m_s2, m_lvl, m_last, m_evt;
    int          m_run [4];
    int          m_mode, m_target, m_mute_left, m_fcnt;
    bit          m_pending, m_paused;
    logic [23:0] m_rgb;

    function automatic int next_mode(input int base, input logic [3:0] ev);
        if (ev[3]) return int'(DEF);
        if (ev[0]) return (base + 1) % 4;
        return (base + 3) % 4;
    endfunction

    function automatic logic [23:0] model_pixel();
        int h3;
        int r;
        if (cx >= sw || cy >= sh || m_mute_left > 0) return 24'h000000;
        case (m_mode)
            0: begin
                h3 = int'(sh) / 3;
                if (int'(cy) < h3) return 24'hff0000;
                if (int'(cy) < h3 * 2) return 24'h00ff00;
                return 24'h0000ff;
            end
            1: begin
                if (cx == 0 || cy == 0 || int'(cx) == int'(sw) - 1 || int'(cy) == int'(sh) - 1)
                    return 24'hffffff;
                return 24'h000000;
            end
            2: return {{8{game_rgb[2]}}, {8{game_rgb[1]}}, {8{game_rgb[0]}}};
            default: begin
                r = (int'(cx) + m_fcnt) % 256;
                return {8'(r), 8'(int'(cy) % 256), 8'(m_fcnt)};
            end
        endcase
    endfunction

    task automatic model_step();
        logic [3:0] ev;
        logic [3:0] nev;
        bit fs;
        if (!rst_n) begin
            m_s1 = '1; m_s2 = '1; m_lvl = '1; m_last = '1; m_evt = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_mode = int'(DEF); m_target = int'(DEF); m_pending = 0;
            m_mute_left = 0; m_fcnt = 0; m_paused = 0; m_rgb = '0;
            return;
        end
        ev  = m_evt;
        nev = '0;
        // a level is accepted once the last DEB delayed samples all agree on it
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] == m_last[i]) m_run[i]++;
            else begin
                m_last[i] = m_s2[i];
                m_run[i]  = 1;
            end
            if (m_last[i] != m_lvl[i] && m_run[i] >= DEB) begin
                nev[i]   = m_lvl[i];
                m_lvl[i] = m_last[i];
            end
        end
        m_evt = nev;
        m_s2  = m_s1;
        m_s1  = key;

        fs = (cx == 0 && cy == 0);
        if (fs && !m_paused) m_fcnt = (m_fcnt + 1) % 256;
        if (ev[2]) m_paused = !m_paused;

        if (m_mute_left > 0) begin
            if (fs) m_mute_left--;
        end else if (!m_pending) begin
            if (ev[3] | ev[0] | ev[1]) begin
                m_target  = next_mode(m_mode, ev);
                m_pending = (m_target != m_mode);
            end
        end else begin
            if (ev[3] | ev[0] | ev[1]) m_target = next_mode(m_target, ev);
            if (fs) begin
                m_pending = 0;
                if (m_target != m_mode) begin
                    m_mode      = m_target;
                    m_mute_left = MF;
                end
            end
        end
        m_rgb = model_pixel();
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        model_step();
        #1;
        check("rgb", rgb, m_rgb);
        check("mode", 24'(mode), 24'(m_mode));
        check("muted", 24'(muted), 24'(m_mute_left > 0));
    endtask

    int  hold_left [4];
    int  gap_left  [4];
    bit  did_mute_rst = 0;

    task automatic drive_keys();
        for (int i = 0; i < 4; i++) begin
            if (hold_left[i] > 0) begin
                key[i] = 1'b0;
                hold_left[i]--;
            end else begin
                key[i] = 1'b1;
                if (gap_left[i] > 0) gap_left[i]--;
                else if ($urandom_range(0, 29) == 0) begin
                    hold_left[i] = $urandom_range(1, 12);
                    gap_left[i]  = $urandom_range(4, 15);
                end
            end
        end
    endtask

    task automatic hold_key(input int k, input int n);
        cx = 10'd5; cy = 10'd5;
        for (int c = 0; c < n + 8; c++) begin
            key    = '1;
            key[k] = (c >= n);
            game_rgb = 3'($urandom);
            tick();
        end
        key = '1;
    endtask

    task automatic run_raster(input int frames, input bit rnd);
        for (int f = 0; f < frames; f++) begin
            sw = 10'($urandom_range(10, 15));
            sh = 10'($urandom_range(6, 9));
            for (int y = 0; y < 10; y++) begin
                for (int x = 0; x < 16; x++) begin
                    cx = 10'(x); cy = 10'(y);
                    game_rgb = 3'($urandom);
                    rst_n = 1'b1;
                    if (rnd) begin
                        drive_keys();
                        if ($urandom_range(0, 2999) == 0) rst_n = 1'b0;
                        if (!did_mute_rst && m_mute_left > 0 && $urandom_range(0, 49) == 0) begin
                            rst_n = 1'b0;
                            did_mute_rst = 1;
                        end
                    end else begin
                        key = '1;
                    end
                    tick();
                    if (!rst_n) begin
                        check("rst_mode", 24'(mode), 24'(DEF));
                        check("rst_muted", 24'(muted), 24'h0);
                        check("rst_rgb", rgb, 24'h0);
                    end
                end
            end
        end
        rst_n = 1'b1;
        key   = '1;
    endtask

    int px [5] = '{0, 639, 5, 5, 700};
    int py [5] = '{5, 5, 479, 5, 5};

    initial begin
        rst_n = 1'b0; key = '1; cx = 10'd5; cy = 10'd5;
        sw = 10'd12; sh = 10'd8; game_rgb = '0;
        for (int i = 0; i < 4; i++) begin
            hold_left[i] = 0;
            gap_left[i]  = 0;
        end
        repeat (3) tick();
        check("reset_mode", 24'(mode), 24'(DEF));
        check("reset_rgb", rgb, 24'h0);
        check("reset_muted", 24'(muted), 24'h0);
        rst_n = 1'b1;

        // short glitch must not register; long press queues a change to mode 3
        hold_key(0, 3);
        hold_key(0, 10);
        run_raster(4, 0);
        // double next from mode 3 within one pending window, then previous
        hold_key(0, 10);
        hold_key(0, 10);
        run_raster(4, 0);
        hold_key(1, 10);
        run_raster(4, 0);
        // default and next in the same cycle; then default on default mode
        cx = 10'd5; cy = 10'd5;
        for (int c = 0; c < 18; c++) begin
            key = (c < 10) ? 4'b0110 : 4'b1111;
            tick();
        end
        run_raster(4, 0);
        hold_key(3, 10);
        run_raster(2, 0);
        // pause across several frames
        hold_key(2, 10);
        run_raster(3, 0);
        hold_key(2, 10);

        run_raster(45, 1);

        // walk to mode 1 and probe border points on a 640x480 screen
        hold_key(3, 10);
        run_raster(4, 0);
        hold_key(1, 10);
        run_raster(4, 0);
        sw = 10'd640; sh = 10'd480;
        for (int c = 0; c < 600; c++) begin
            if (c % 7 < 5) begin
                cx = 10'(px[c % 7]); cy = 10'(py[c % 7]);
            end else begin
                cx = 10'($urandom_range(0, 1023));
                cy = 10'($urandom_range(0, 1023));
            end
            game_rgb = 3'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
